// File: rtl/axi_dma_wr_simple.sv
// Stream-to-memory AXI4 write DMA. A command is split into INCR bursts that
// stay within MAX_BURST_LEN beats and a 4 KB page; one AW/W/B is in flight.

module axi_dma_wr_simple #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH/8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SIZE = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [8:0]            beats_q, beats_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  unused_bid;

  // Beats for the next burst: limited by words left, MAX_BURST_LEN and room to the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [LEN_WIDTH-1:0]  rem);
    logic [31:0] lim;
    logic [31:0] room;
    lim = 32'(rem);
    if (lim > 32'(MAX_BURST_LEN)) lim = 32'(MAX_BURST_LEN);
    room = (32'd4096 - (32'(addr) & 32'h0000_0FFF)) >> SIZE;
    if (ADDR_WIDTH > 12 && room < lim) lim = room;
    return 9'(lim);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    awvalid_d   = awvalid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          addr_d      = cmd_addr & ALIGN_MASK;
          remaining_d = cmd_len;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            beats_d   = burst_beats(cmd_addr & ALIGN_MASK, cmd_len);
            awvalid_d = 1'b1;
            state_d   = AW;
          end
        end
      end
      AW: begin
        if (m_axi_awready) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = 8'(beats_q - 9'd1);
          state_d    = W;
        end
      end
      W: begin
        if (s_axis_tvalid && m_axi_wready) begin
          if (beat_cnt_q == 8'd0) begin
            remaining_d = remaining_q - LEN_WIDTH'(beats_q);
            addr_d      = addr_q + ADDR_WIDTH'(32'(beats_q) << SIZE);
            state_d     = B;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          if (remaining_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            beats_d   = burst_beats(addr_q, remaining_q);
            awvalid_d = 1'b1;
            state_d   = AW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      awvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      awvalid_q   <= awvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Every channel transfers on a cycle where valid && ready; a raised valid holds
  // its payload until that cycle. The W channel is a direct pass-through of the
  // stream while a burst is open, so tvalid/tready inherit the same rule.
  // busy_q blocks a new accept during the done cycle of a zero-length command.
  assign cmd_ready     = (state_q == IDLE) && !busy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(beats_q - 9'd1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == W) && s_axis_tvalid;
  assign s_axis_tready = (state_q == W) && m_axi_wready;
  assign m_axi_wlast   = (state_q == W) && (beat_cnt_q == 8'd0);

  assign m_axi_bready  = (state_q == B);
  assign unused_bid    = ^m_axi_bid;

endmodule

// File: tb/tb_axi_dma_wr_simple.sv
// Directed bench for axi_dma_wr_simple with a behavioural AXI RAM slave,
// a negedge bus monitor and per-scenario tasks.

module tb_axi_dma_wr_simple;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        busy, done, error;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  axi_dma_wr_simple dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .busy(busy), .done(done), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  // ---------------- slave knobs and monitor state ----------------
  bit          bp_en = 1'b0;
  bit          wready_block = 1'b0;
  int          err_burst = -1;
  int          b_issued = 0;

  logic [31:0] mem [0:16383];
  logic [15:0] aw_addr_log [$];
  logic [7:0]  aw_len_log [$];
  int          cyc = 0, w_beats = 0, wlast_cnt = 0, wlast_err = 0, b_hs_cnt = 0;
  int          done_cnt = 0, proto_err = 0, busy_cycles = 0, awvalid_cycles = 0;
  int          accept_cyc = 0, first_aw_cyc = 0, done_cyc = 0;
  logic        done_err = 1'b0;

  // Bus monitor: samples at negedge, i.e. the values the next posedge will act on.
  initial begin
    bit          in_burst, aw_wait, wait_first_aw;
    int          beat_idx;
    logic [7:0]  cur_len, held_len;
    logic [15:0] cur_addr, held_addr;
    in_burst = 0; aw_wait = 0; wait_first_aw = 0; beat_idx = 0;
    cur_len = '0; held_len = '0; cur_addr = '0; held_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_burst = 0;
        aw_wait = 0;
        wait_first_aw = 0;
      end else begin
        if (busy) busy_cycles++;
        if (m_axi_awvalid) awvalid_cycles++;
        if (m_axi_awvalid && wait_first_aw) begin
          first_aw_cyc = cyc;
          wait_first_aw = 0;
        end
        if (cmd_valid && cmd_ready) begin
          accept_cyc = cyc;
          wait_first_aw = 1;
        end
        if (aw_wait && (!m_axi_awvalid || m_axi_awaddr !== held_addr || m_axi_awlen !== held_len))
          proto_err++;
        aw_wait = m_axi_awvalid && !m_axi_awready;
        held_addr = m_axi_awaddr;
        held_len = m_axi_awlen;
        if (m_axi_wvalid && !s_axis_tvalid) proto_err++;
        if (m_axi_wvalid && m_axi_wdata !== s_axis_tdata) proto_err++;
        if (m_axi_wvalid && !in_burst) proto_err++;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_addr_log.push_back(m_axi_awaddr);
          aw_len_log.push_back(m_axi_awlen);
          in_burst = 1;
          beat_idx = 0;
          cur_len = m_axi_awlen;
          cur_addr = m_axi_awaddr;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          mem[cur_addr[15:2]] = m_axi_wdata;
          w_beats++;
          if (m_axi_wlast !== (beat_idx == 32'(cur_len))) wlast_err++;
          beat_idx++;
          cur_addr = cur_addr + 16'd4;
          if (m_axi_wlast) begin
            wlast_cnt++;
            in_burst = 0;
          end
        end
        if (m_axi_bvalid && m_axi_bready) b_hs_cnt++;
        if (done) begin
          done_cnt++;
          done_err = error;
          done_cyc = cyc;
        end
      end
    end
  end

  // Behavioural RAM slave handshakes; inputs change at posedge+1.
  initial begin
    int b_seen;
    b_seen = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bid = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        b_seen = b_hs_cnt;
      end else begin
        if (m_axi_bvalid && b_hs_cnt != b_seen) begin
          m_axi_bvalid = 1'b0;
          b_seen = b_hs_cnt;
        end
        m_axi_awready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_wready = wready_block ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (!m_axi_bvalid && wlast_cnt > b_issued && (!bp_en || $urandom_range(0, 2) == 0)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp = (b_issued == err_burst) ? 2'b10 : 2'b00;
          b_issued++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [15:0] a, input logic [15:0] l);
    int guard;
    guard = 0;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    do begin @(negedge clk); guard++; end while (!cmd_ready && guard < 2000);
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_stream(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      if (!rst_n) break;
      if (bp_en) repeat ($urandom_range(0, 2)) begin s_axis_tvalid = 1'b0; @(posedge clk); #1; end
      s_axis_tvalid = 1'b1;
      s_axis_tdata = base + 32'(i);
      do begin @(negedge clk); guard++; end while (!s_axis_tready && rst_n && guard < 2000);
      if (rst_n && !s_axis_tready) begin
        checks++; failures++;
        $display("FAIL stream_timeout: word %0d not taken, tready=%b, required 1", i, s_axis_tready);
        break;
      end
      if (!rst_n) break;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < 5000) begin @(posedge clk); #1; guard++; end
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL %s_timeout: done count %0d, required %0d", name, done_cnt, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [7:0] obs;
    repeat (2) @(posedge clk);
    #1;
    obs = {cmd_ready, busy, done, error, m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready};
    checks++;
    if (obs !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_outputs: {rdy,busy,done,err,awv,wv,trdy,brdy}=%b, required 10000000", obs);
    end
    checks++;
    if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wstrb}
        !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF}) begin
      failures++;
      $display("FAIL aw_constants: id=%h size=%0d burst=%b lock=%b cache=%b prot=%b strb=%h",
               m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wstrb);
    end
    checks++;
    if (m_axi_awaddr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_awaddr: got %h, required 0000", m_axi_awaddr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int aw0, d0, b0;
    aw0 = aw_addr_log.size(); d0 = done_cnt; b0 = b_hs_cnt;
    fork
      send_cmd(16'h0100, 16'd4);
      drive_stream(4, 32'hA0);
    join
    wait_done(d0 + 1, "basic");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (aw_addr_log.size() - aw0 != 1 || aw_addr_log[aw0] !== 16'h0100 || aw_len_log[aw0] !== 8'd3) begin
      failures++;
      $display("FAIL basic_aw: count=%0d addr=%h len=%0d, required count=1 addr=0100 len=3",
               aw_addr_log.size() - aw0, aw_addr_log[aw0], aw_len_log[aw0]);
    end
    checks++;
    if (first_aw_cyc - accept_cyc != 1) begin
      failures++;
      $display("FAIL basic_aw_latency: %0d cycles, required 1", first_aw_cyc - accept_cyc);
    end
    checks++;
    if (done_cnt - d0 != 1 || b_hs_cnt - b0 != 1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: dones=%0d bs=%0d err=%b, required 1 1 0", done_cnt - d0, b_hs_cnt - b0, done_err);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[14'(16'h0040 + i)] !== 32'hA0 + 32'(i)) begin
        failures++;
        $display("FAIL basic_mem%0d: got %h, required %h", i, mem[14'(16'h0040 + i)], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_split;
    int aw0, d0, b0;
    logic [15:0] ea [3];
    logic [7:0]  el [3];
    ea = '{16'h0000, 16'h0040, 16'h0080};
    el = '{8'd15, 8'd15, 8'd7};
    aw0 = aw_addr_log.size(); d0 = done_cnt; b0 = b_hs_cnt;
    fork
      send_cmd(16'h0000, 16'd40);
      drive_stream(40, 32'h1000);
    join
    wait_done(d0 + 1, "split");
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (aw_addr_log[aw0 + k] !== ea[k] || aw_len_log[aw0 + k] !== el[k]) begin
        failures++;
        $display("FAIL split_aw%0d: addr=%h len=%0d, required addr=%h len=%0d",
                 k, aw_addr_log[aw0 + k], aw_len_log[aw0 + k], ea[k], el[k]);
      end
    end
    checks++;
    if (aw_addr_log.size() - aw0 != 3 || b_hs_cnt - b0 != 3 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL split_counts: aw=%0d b=%0d done=%0d, required 3 3 1",
               aw_addr_log.size() - aw0, b_hs_cnt - b0, done_cnt - d0);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (mem[14'(i)] !== 32'h1000 + 32'(i)) begin
        failures++;
        $display("FAIL split_mem%0d: got %h, required %h", i, mem[14'(i)], 32'h1000 + 32'(i));
      end
    end
  endtask

  task automatic test_4k_boundary;
    int aw0, d0;
    aw0 = aw_addr_log.size(); d0 = done_cnt;
    fork
      send_cmd(16'h0FF8, 16'd4);
      drive_stream(4, 32'h2000);
    join
    wait_done(d0 + 1, "4k");
    checks++;
    if (aw_addr_log.size() - aw0 != 2 || aw_addr_log[aw0] !== 16'h0FF8 || aw_len_log[aw0] !== 8'd1
        || aw_addr_log[aw0 + 1] !== 16'h1000 || aw_len_log[aw0 + 1] !== 8'd1) begin
      failures++;
      $display("FAIL 4k_aw: n=%0d %h/%0d %h/%0d, required 2 0ff8/1 1000/1", aw_addr_log.size() - aw0,
               aw_addr_log[aw0], aw_len_log[aw0], aw_addr_log[aw0 + 1], aw_len_log[aw0 + 1]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[14'(16'h03FE + i)] !== 32'h2000 + 32'(i)) begin
        failures++;
        $display("FAIL 4k_mem%0d: got %h, required %h", i, mem[14'(16'h03FE + i)], 32'h2000 + 32'(i));
      end
    end
  endtask

  task automatic test_zero_len;
    int aw0, d0, bc0, av0;
    aw0 = aw_addr_log.size(); d0 = done_cnt; bc0 = busy_cycles; av0 = awvalid_cycles;
    send_cmd(16'h0400, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1 || done_cyc - accept_cyc != 1) begin
      failures++;
      $display("FAIL zero_done: dones=%0d latency=%0d, required 1 1", done_cnt - d0, done_cyc - accept_cyc);
    end
    checks++;
    if (busy_cycles - bc0 != 1) begin
      failures++;
      $display("FAIL zero_busy: busy cycles=%0d, required 1", busy_cycles - bc0);
    end
    checks++;
    if (awvalid_cycles - av0 != 0 || aw_addr_log.size() - aw0 != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_no_axi: awvalid cycles=%0d aws=%0d cmd_ready=%b, required 0 0 1",
               awvalid_cycles - av0, aw_addr_log.size() - aw0, cmd_ready);
    end
  endtask

  task automatic test_backpressure;
    int aw0, d0, w0;
    logic [15:0] ea [3];
    logic [7:0]  el [3];
    ea = '{16'h1F80, 16'h1FC0, 16'h2000};
    el = '{8'd15, 8'd15, 8'd4};
    aw0 = aw_addr_log.size(); d0 = done_cnt; w0 = w_beats;
    bp_en = 1'b1;
    fork
      send_cmd(16'h1F80, 16'd37);
      drive_stream(37, 32'h3000);
    join
    wait_done(d0 + 1, "bp");
    bp_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (aw_addr_log[aw0 + k] !== ea[k] || aw_len_log[aw0 + k] !== el[k]) begin
        failures++;
        $display("FAIL bp_aw%0d: addr=%h len=%0d, required addr=%h len=%0d",
                 k, aw_addr_log[aw0 + k], aw_len_log[aw0 + k], ea[k], el[k]);
      end
    end
    checks++;
    if (w_beats - w0 != 37 || proto_err != 0 || wlast_err != 0) begin
      failures++;
      $display("FAIL bp_protocol: beats=%0d proto_err=%0d wlast_err=%0d, required 37 0 0",
               w_beats - w0, proto_err, wlast_err);
    end
    for (int i = 0; i < 37; i++) begin
      checks++;
      if (mem[14'(16'h07E0 + i)] !== 32'h3000 + 32'(i)) begin
        failures++;
        $display("FAIL bp_mem%0d: got %h, required %h", i, mem[14'(16'h07E0 + i)], 32'h3000 + 32'(i));
      end
    end
  endtask

  task automatic test_error;
    int aw0, d0, b0;
    aw0 = aw_addr_log.size(); d0 = done_cnt; b0 = b_hs_cnt;
    err_burst = b_issued + 1;
    fork
      send_cmd(16'h3000, 16'd40);
      drive_stream(40, 32'h4000);
    join
    wait_done(d0 + 1, "error");
    err_burst = -1;
    checks++;
    if (aw_addr_log.size() - aw0 != 3 || b_hs_cnt - b0 != 3 || aw_addr_log[aw0 + 2] !== 16'h3080) begin
      failures++;
      $display("FAIL error_bursts: aws=%0d bs=%0d last addr=%h, required 3 3 3080",
               aw_addr_log.size() - aw0, b_hs_cnt - b0, aw_addr_log[aw0 + 2]);
    end
    checks++;
    if (done_err !== 1'b1) begin
      failures++;
      $display("FAIL error_at_done: error=%b, required 1", done_err);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL error_held: error=%b, required 1", error);
    end
  endtask

  task automatic test_back_to_back;
    int aw0, d0;
    aw0 = aw_addr_log.size(); d0 = done_cnt;
    fork
      begin
        send_cmd(16'h0503, 16'd2);
        checks++;
        if (error !== 1'b0) begin
          failures++;
          $display("FAIL b2b_error_clear: error=%b after accept, required 0", error);
        end
        send_cmd(16'h0600, 16'd3);
      end
      begin
        drive_stream(2, 32'h5000);
        drive_stream(3, 32'h5100);
      end
    join
    wait_done(d0 + 2, "b2b");
    checks++;
    if (aw_addr_log[aw0] !== 16'h0500 || aw_len_log[aw0] !== 8'd1
        || aw_addr_log[aw0 + 1] !== 16'h0600 || aw_len_log[aw0 + 1] !== 8'd2) begin
      failures++;
      $display("FAIL b2b_aw: %h/%0d %h/%0d, required 0500/1 0600/2",
               aw_addr_log[aw0], aw_len_log[aw0], aw_addr_log[aw0 + 1], aw_len_log[aw0 + 1]);
    end
    checks++;
    if (mem[14'h0140] !== 32'h5000 || mem[14'h0141] !== 32'h5001 || mem[14'h0182] !== 32'h5102
        || done_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_mem: %h %h %h err=%b, required 5000 5001 5102 0",
               mem[14'h0140], mem[14'h0141], mem[14'h0182], done_err);
    end
  endtask

  task automatic test_reset_mid_burst;
    int w0, aw0, d0;
    logic [7:0] obs;
    w0 = w_beats;
    fork
      send_cmd(16'h0200, 16'd8);
      drive_stream(8, 32'h6000);
      begin
        int guard;
        guard = 0;
        while (w_beats < w0 + 3 && guard < 2000) begin @(negedge clk); guard++; end
        wready_block = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_axi_wvalid !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL rst_pre_state: wvalid=%b busy=%b, required 1 1", m_axi_wvalid, busy);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        obs = {cmd_ready, busy, done, error, m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready};
        checks++;
        if (obs !== 8'b1000_0000) begin
          failures++;
          $display("FAIL rst_async_outputs: {rdy,busy,done,err,awv,wv,trdy,brdy}=%b, required 10000000", obs);
        end
        repeat (2) @(posedge clk);
        #1;
        wready_block = 1'b0;
        rst_n = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    aw0 = aw_addr_log.size(); d0 = done_cnt; w0 = w_beats;
    fork
      send_cmd(16'h0300, 16'd2);
      drive_stream(2, 32'h7000);
    join
    wait_done(d0 + 1, "post_rst");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (aw_addr_log.size() - aw0 != 1 || aw_addr_log[aw0] !== 16'h0300 || aw_len_log[aw0] !== 8'd1
        || w_beats - w0 != 2) begin
      failures++;
      $display("FAIL post_rst_axi: aws=%0d addr=%h len=%0d beats=%0d, required 1 0300 1 2",
               aw_addr_log.size() - aw0, aw_addr_log[aw0], aw_len_log[aw0], w_beats - w0);
    end
    checks++;
    if (mem[14'h00C0] !== 32'h7000 || mem[14'h00C1] !== 32'h7001 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_mem: %h %h err=%b, required 7000 7001 0", mem[14'h00C0], mem[14'h00C1], done_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_4k_boundary();
    test_zero_len();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_reset_mid_burst();
    checks++;
    if (proto_err != 0 || wlast_err != 0) begin
      failures++;
      $display("FAIL protocol_total: proto_err=%0d wlast_err=%0d, required 0 0", proto_err, wlast_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
